// File: rtl/cordic_iter_ctrl.sv
// Iterative sequencer for a shared cordic_stage: runs NUM_ITER micro-rotations per operand.
// Optional CORDIC_ITER_OVERRIDE_EN adds cfg_iters to set the iteration count per operand.
module cordic_iter_ctrl #(
    parameter int W         = 9,
    parameter int NUM_ITER  = 8,
    parameter int STAGE_LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [W-1:0] in_z,
`ifdef CORDIC_ITER_OVERRIDE_EN
    input  logic [3:0]   cfg_iters,
`endif
    output logic [W-1:0] st_x,
    output logic [W-1:0] st_y,
    output logic [W-1:0] st_z,
    output logic [W-1:0] st_mem,
    output logic [2:0]   st_count,
    input  logic [W-1:0] st_xr,
    input  logic [W-1:0] st_yr,
    input  logic [W-1:0] st_zr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic [W-1:0] out_z,
    output logic         busy
);

    localparam logic [2:0] LAST = 3'(NUM_ITER - 1);
    localparam logic [2:0] WLAT = 3'(STAGE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] rx, ry, rz;
    logic [W-1:0] rx_nx, ry_nx, rz_nx;
    logic [2:0]   iter, iter_nx;
    logic [2:0]   wcnt, wcnt_nx;
    logic [2:0]   last_idx;

`ifdef CORDIC_ITER_OVERRIDE_EN
    logic [2:0] lim, lim_nx, lim_load;

    always_comb begin
        if (cfg_iters == 4'd0 || cfg_iters > 4'd8)
            lim_load = LAST;
        else
            lim_load = 3'(cfg_iters - 4'd1);
    end

    assign last_idx = lim;
`else
    assign last_idx = LAST;
`endif

    function automatic logic [W-1:0] arctan(input logic [2:0] i);
        logic [W-1:0] v;
        v = '0;
        unique case (i)
            3'd0: v = W'(45);
            3'd1: v = W'(27);
            3'd2: v = W'(14);
            3'd3: v = W'(7);
            3'd4: v = W'(4);
            3'd5: v = W'(2);
            3'd6: v = W'(1);
            3'd7: v = W'(0);
        endcase
        return v;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rx    <= '0;
            ry    <= '0;
            rz    <= '0;
            iter  <= '0;
            wcnt  <= '0;
`ifdef CORDIC_ITER_OVERRIDE_EN
            lim   <= '0;
`endif
        end else begin
            state <= state_nx;
            rx    <= rx_nx;
            ry    <= ry_nx;
            rz    <= rz_nx;
            iter  <= iter_nx;
            wcnt  <= wcnt_nx;
`ifdef CORDIC_ITER_OVERRIDE_EN
            lim   <= lim_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        rx_nx    = rx;
        ry_nx    = ry;
        rz_nx    = rz;
        iter_nx  = iter;
        wcnt_nx  = wcnt;
`ifdef CORDIC_ITER_OVERRIDE_EN
        lim_nx   = lim;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    rx_nx    = in_x;
                    ry_nx    = in_y;
                    rz_nx    = in_z;
                    iter_nx  = '0;
`ifdef CORDIC_ITER_OVERRIDE_EN
                    lim_nx   = lim_load;
`endif
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_nx  = WLAT;
                state_nx = WAIT;
            end
            WAIT: begin
                if (wcnt != 3'd0) begin
                    wcnt_nx = wcnt - 3'd1;
                end else begin
                    rx_nx = st_xr;
                    ry_nx = st_yr;
                    rz_nx = st_zr;
                    if (iter == last_idx) begin
                        state_nx = DONE;
                    end else begin
                        iter_nx  = iter + 3'd1;
                        state_nx = ISSUE;
                    end
                end
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    assign st_x     = rx;
    assign st_y     = ry;
    assign st_z     = rz;
    assign st_count = iter;
    // Constant is only meaningful while a run is active; idle keeps it at zero.
    assign st_mem   = busy ? arctan(iter) : '0;

    assign out_x = rx;
    assign out_y = ry;
    assign out_z = rz;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: two instances (8x1 and 4x3 iter/latency) on behavioural stages.
// Expected vectors come from a plain CORDIC reference applied n times to the accepted operand.
module tb_cordic_iter_ctrl;

    localparam int W  = 9;
    localparam int N0 = 8;
    localparam int L0 = 1;
    localparam int N1 = 4;
    localparam int L1 = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic         iv[2], ir[2], orr[2], ov[2], bz[2];
    logic [W-1:0] ix[2], iy[2], iz[2];
    logic [W-1:0] sx[2], sy[2], sz[2], sm[2];
    logic [W-1:0] sxr[2], syr[2], szr[2];
    logic [W-1:0] ox[2], oy[2], oz[2];
    logic [2:0]   sc[2];
`ifdef CORDIC_ITER_OVERRIDE_EN
    logic [3:0]   cfg[2];
`endif

    int checks   = 0;
    int failures = 0;

    cordic_iter_ctrl #(.W(W), .NUM_ITER(N0), .STAGE_LAT(L0)) dut (
        .clock(clock), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_x(ix[0]), .in_y(iy[0]), .in_z(iz[0]),
`ifdef CORDIC_ITER_OVERRIDE_EN
        .cfg_iters(cfg[0]),
`endif
        .st_x(sx[0]), .st_y(sy[0]), .st_z(sz[0]),
        .st_mem(sm[0]), .st_count(sc[0]),
        .st_xr(sxr[0]), .st_yr(syr[0]), .st_zr(szr[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .out_x(ox[0]), .out_y(oy[0]), .out_z(oz[0]),
        .busy(bz[0])
    );

    cordic_iter_ctrl #(.W(W), .NUM_ITER(N1), .STAGE_LAT(L1)) dut3 (
        .clock(clock), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_x(ix[1]), .in_y(iy[1]), .in_z(iz[1]),
`ifdef CORDIC_ITER_OVERRIDE_EN
        .cfg_iters(cfg[1]),
`endif
        .st_x(sx[1]), .st_y(sy[1]), .st_z(sz[1]),
        .st_mem(sm[1]), .st_count(sc[1]),
        .st_xr(sxr[1]), .st_yr(syr[1]), .st_zr(szr[1]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .out_x(ox[1]), .out_y(oy[1]), .out_z(oz[1]),
        .busy(bz[1])
    );

    function automatic logic [W-1:0] rom_m(int i);
        int t[8];
        t = '{45, 27, 14, 7, 4, 2, 1, 0};
        return W'(t[i]);
    endfunction

    // One rotation-mode micro-rotation, wrapping at W bits.
    function automatic logic [3*W-1:0] step(logic [W-1:0] x, logic [W-1:0] y,
                                            logic [W-1:0] z, logic [W-1:0] m,
                                            int i);
        logic signed [W-1:0] a, b, c, na, nb, nc;
        a = x;
        b = y;
        c = z;
        if (c >= 0) begin
            na = a - (b >>> i);
            nb = b + (a >>> i);
            nc = c - $signed(m);
        end else begin
            na = a + (b >>> i);
            nb = b - (a >>> i);
            nc = c + $signed(m);
        end
        return {na, nb, nc};
    endfunction

    function automatic logic [3*W-1:0] model(logic [W-1:0] x, logic [W-1:0] y,
                                             logic [W-1:0] z, int n);
        logic [3*W-1:0] v;
        v = {x, y, z};
        for (int i = 0; i < n; i++)
            v = step(v[3*W-1:2*W], v[2*W-1:W], v[W-1:0], rom_m(i), i);
        return v;
    endfunction

    function automatic int neff(int d, logic [3:0] c);
        int base;
        base = (d == 0) ? N0 : N1;
`ifdef CORDIC_ITER_OVERRIDE_EN
        if (c == 4'd0 || c > 4'd8)
            return base;
        return int'(c);
`else
        if (c > 4'd15)
            return 0;
        return base;
`endif
    endfunction

    // Behavioural stages: registered micro-rotation, then extra delay stages.
    logic [3*W-1:0] p0;
    logic [3*W-1:0] p1[L1];

    always_ff @(posedge clock) begin
        p0    <= step(sx[0], sy[0], sz[0], sm[0], int'(sc[0]));
        p1[0] <= step(sx[1], sy[1], sz[1], sm[1], int'(sc[1]));
        for (int j = 1; j < L1; j++)
            p1[j] <= p1[j-1];
    end

    assign {sxr[0], syr[0], szr[0]} = p0;
    assign {sxr[1], syr[1], szr[1]} = p1[L1-1];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts and ends at a falling edge with the instance idle.
    task automatic run_op(int d, logic [W-1:0] x, logic [W-1:0] y,
                          logic [W-1:0] z, int hold, logic [3:0] c,
                          output logic [3*W-1:0] seen);
        int n, l, i;
        logic [3*W-1:0] ex, fin;
        n = neff(d, c);
        l = (d == 0) ? L0 : L1;
        fin = model(x, y, z, n);
        iv[d] = 1'b1;
        ix[d] = x;
        iy[d] = y;
        iz[d] = z;
`ifdef CORDIC_ITER_OVERRIDE_EN
        cfg[d] = c;
`endif
        chk("accept_ready", 32'(ir[d]), 1);
        @(negedge clock);
        for (int e = 0; e < n * (l + 1); e++) begin
            i  = e / (l + 1);
            ex = model(x, y, z, i);
            chk("st_count", 32'(sc[d]), 32'(i));
            chk("st_mem", 32'(sm[d]), 32'(rom_m(i)));
            chk("st_vec", 32'({sx[d], sy[d], sz[d]}), 32'(ex));
            chk("busy_run", 32'(bz[d]), 1);
            chk("ready_run", 32'(ir[d]), 0);
            chk("valid_run", 32'(ov[d]), 0);
            iv[d]  = 1'($urandom);
            ix[d]  = W'($urandom);
            iy[d]  = W'($urandom);
            iz[d]  = W'($urandom);
            orr[d] = 1'($urandom);
`ifdef CORDIC_ITER_OVERRIDE_EN
            cfg[d] = 4'($urandom);
`endif
            @(negedge clock);
        end
        seen = {ox[d], oy[d], oz[d]};
        for (int h = 0; h < hold; h++) begin
            orr[d] = 1'b0;
            iv[d]  = 1'($urandom);
            chk("hold_valid", 32'(ov[d]), 1);
            chk("hold_data", 32'({ox[d], oy[d], oz[d]}), 32'(fin));
            chk("hold_ready", 32'(ir[d]), 0);
            @(negedge clock);
        end
        chk("out_valid", 32'(ov[d]), 1);
        chk("out_data", 32'({ox[d], oy[d], oz[d]}), 32'(fin));
        orr[d] = 1'b1;
        iv[d]  = 1'b1;
        ix[d]  = W'($urandom);
        @(negedge clock);
        chk("release_valid", 32'(ov[d]), 0);
        chk("release_ready", 32'(ir[d]), 1);
        chk("release_busy", 32'(bz[d]), 0);
        orr[d] = 1'b0;
        iv[d]  = 1'b0;
    endtask

    initial begin
        logic [3*W-1:0] seen;
        logic signed [W-1:0] sy_s, sz_s;
        int vcount;
        for (int d = 0; d < 2; d++) begin
            iv[d]  = 1'b0;
            orr[d] = 1'b0;
            ix[d]  = '0;
            iy[d]  = '0;
            iz[d]  = '0;
`ifdef CORDIC_ITER_OVERRIDE_EN
            cfg[d] = 4'd0;
`endif
        end
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ir[d]), 1);
            chk("rst_busy", 32'(bz[d]), 0);
            chk("rst_valid", 32'(ov[d]), 0);
            chk("rst_out", 32'({ox[d], oy[d], oz[d]}), 0);
            chk("rst_st", 32'({sx[d], sm[d], sc[d]}), 0);
        end
        @(negedge clock);

        run_op(0, W'(100), W'(0), W'(30), 5, 4'd0, seen);
        sy_s = seen[2*W-1:W];
        sz_s = seen[W-1:0];
        chk("golden_z_small", 32'(sz_s >= -2 && sz_s <= 2), 1);
        chk("golden_y_sin30", 32'(sy_s >= 70 && sy_s <= 95), 1);

        for (int k = 0; k < 3; k++)
            run_op(0, W'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)), 4'($urandom), seen);

        iv[0] = 1'b1;
        ix[0] = W'(100);
        iy[0] = W'(0);
        iz[0] = W'(30);
        @(negedge clock);
        iv[0] = 1'b0;
        repeat (6) @(negedge clock);
        chk("mid_iter", 32'(sc[0]), 3);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", 32'(bz[0]), 0);
        chk("async_ready", 32'(ir[0]), 1);
        chk("async_valid", 32'(ov[0]), 0);
        chk("async_regs", 32'({sx[0], sy[0], sz[0], sc[0]}), 0);
        @(negedge clock);
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (ov[0])
                vcount++;
            @(negedge clock);
        end
        chk("abandoned_no_out", 32'(vcount), 0);
        run_op(0, W'($urandom), W'($urandom), W'($urandom), 1, 4'd0, seen);

        run_op(1, W'(100), W'(0), W'(30), 2, 4'd2, seen);
        run_op(1, W'($urandom), W'($urandom), W'($urandom), 0, 4'd0, seen);
        run_op(1, W'($urandom), W'($urandom), W'($urandom), 1, 4'd9, seen);
        for (int k = 0; k < 2; k++)
            run_op(1, W'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)), 4'($urandom), seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Sequencer for one shared cordic_stage datapath, used iteratively to run a full rotation-mode CORDIC.
- Accepts an (x, y, z) operand through a valid/ready handshake.
- Issues NUM_ITER iterations to the stage, supplying the per-iteration shift count and arctan constant.
- Captures each stage result and feeds it back as the next iteration's operand.
- Presents the final vector through a valid/ready output handshake.
- Sits between the operand source and the single cordic_stage instance.

Parameters:
W, 9, data width of x/y/z/mem (two's complement)
NUM_ITER, 8, iterations per operand, legal 1..8
STAGE_LAT, 1, clock cycles from stage input to registered stage output, legal 1..4

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
in_valid  in  1  operand offered
in_ready  out  1  controller can accept operand
in_x  in  W  initial x
in_y  in  W  initial y
in_z  in  W  initial angle, 1 LSB = 1 degree
st_x  out  W  operand x to stage
st_y  out  W  operand y to stage
st_z  out  W  operand z to stage
st_mem  out  W  arctan constant for current iteration
st_count  out  3  shift amount = iteration index
st_xr  in  W  stage result x
st_yr  in  W  stage result y
st_zr  in  W  stage result z
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_x  out  W  final x
out_y  out  W  final y
out_z  out  W  residual angle
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready=1; internal registers cleared.
  - Asserting reset mid-operation abandons the operand with no output.
- Arctan ROM (degrees, indexed by iter): 45, 27, 14, 7, 4, 2, 1, 0.
- Registers: rx, ry, rz (W); iter (3b); wcnt (3b); state.
- st_x/st_y/st_z always equal rx/ry/rz.
- st_count = iter; st_mem = ROM[iter].
- IDLE:
  - in_ready=1.
  - On in_valid: load rx/ry/rz from in_x/in_y/in_z, iter=0, go ISSUE.
- ISSUE (1 cycle):
  - in_ready=0.
  - wcnt=STAGE_LAT-1; go WAIT.
- WAIT:
  - If wcnt!=0: decrement.
  - If wcnt==0: capture rx/ry/rz from st_xr/st_yr/st_zr.
    - If iter==NUM_ITER-1: go DONE.
    - Else: iter+1, go ISSUE.
- Operand stability: st_x/st_y/st_z and st_count/st_mem are stable from ISSUE until capture.
- DONE:
  - out_valid=1; out_x/out_y/out_z = rx/ry/rz, held stable while out_valid && !out_ready.
  - On out_ready: go IDLE.
- Latency, accept edge to out_valid high = 1 + NUM_ITER*(STAGE_LAT+1) cycles. Default: 17.
- Throughput: one operand per latency + 1 cycle minimum; no overlap.
- Boundary conditions:
  - in_valid while busy: ignored (in_ready=0); no operand is latched.
  - out_ready while not DONE: no effect.
  - In DONE, out_ready and in_valid together: return to IDLE; the new operand is accepted on the following edge, not the same one.
  - NUM_ITER=1: single ISSUE/WAIT then DONE.
  - iter never exceeds NUM_ITER-1; no wrap.
- No arithmetic in the controller; widths pass through unchanged. Overflow behaviour belongs to the stage.

Optional Feature:
Macro CORDIC_ITER_OVERRIDE_EN.
- Defined:
  - Adds input cfg_iters (4b), sampled only on the IDLE accept edge into an internal limit register.
  - A value of 0 or greater than 8 is clamped to NUM_ITER.
  - The termination test uses the limit register instead of NUM_ITER.
  - Changing cfg_iters mid-operation has no effect.
- Undefined: port absent; the termination count is NUM_ITER.

Test Plan:
1. Reset check: reset asserted asynchronously between edges -> outputs zero and in_ready=1 immediately; after release, idle with busy=0.
2. Single operation, defaults, stub stage echoing inputs with 1-cycle latency:
   - Stimulus: in_x=100, in_y=0, in_z=30 accepted at edge k.
   - Required: st_count sequences 0..7 with st_mem 45, 27, 14, 7, 4, 2, 1, 0, each on ISSUE cycles k+1, k+3, ..., k+15.
   - Required: out_valid rises at k+17 with out = (100, 0, 30).
3. Real cordic_stage: in (100, 0, 30) -> out_z within ±2 of 0; out_y positive and proportional to sin 30°, per the golden model.
4. Backpressure:
   - out_ready held low 5 cycles after out_valid -> out_valid stays 1 with stable data.
   - in_valid pulses during busy are not accepted.
   - After out_ready, the next operand is accepted one edge later.
5. Reset mid-operation: assert reset at iteration 3 -> busy=0, out_valid never asserts; next operand completes normally in 17 cycles.
6. STAGE_LAT=3, NUM_ITER=4 (and, with CORDIC_ITER_OVERRIDE_EN, cfg_iters=2 or 0) -> latency 17, 9, and the NUM_ITER default respectively; st_* held stable for 4 cycles per iteration.
